// File: rtl/cache_pkg.sv
// Shared constants, offset-width helper and FSM state encoding for the
// line fill path between the cache controller and main memory.
package cache_pkg;

    localparam int CACHE_ADDR_W     = 32;
    localparam int CACHE_LINE_BYTES = 4;

    function automatic int off_width(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/line_beat_sequencer.sv
// Beat/wait counters for byte-serial memory traffic: each beat lasts
// WAIT_CYCLES+1 cycles, and LINE_BYTES beats make up a line.
module line_beat_sequencer
    import cache_pkg::*;
#(
    parameter int LINE_BYTES  = CACHE_LINE_BYTES,
    parameter int WAIT_CYCLES = 0,
    localparam int OFF_W      = off_width(LINE_BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    output logic [OFF_W-1:0] beat_idx,
    output logic             beat_last_cycle,
    output logic             line_done
);

    localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(WAIT_CYCLES);
    localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(LINE_BYTES - 1);

    logic [WAIT_W-1:0] wait_reg;
    logic [OFF_W-1:0]  beat_reg;

    // Beat counter wraps to 0 after the last beat, so a WB->FILL hand-over
    // starts the fill at beat 0 without an explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_reg <= '0;
            beat_reg <= '0;
        end else if (!active) begin
            wait_reg <= '0;
            beat_reg <= '0;
        end else if (wait_reg == WAIT_MAX) begin
            wait_reg <= '0;
            beat_reg <= beat_reg + OFF_W'(1);
        end else begin
            wait_reg <= wait_reg + WAIT_W'(1);
        end
    end

    assign beat_idx        = beat_reg;
    assign beat_last_cycle = active && (wait_reg == WAIT_MAX);
    assign line_done       = beat_last_cycle && (beat_reg == LAST_BEAT);

endmodule

// File: rtl/line_fill_engine.sv
// Miss handler: optional byte-serial write-back of a dirty victim, then a
// byte-serial line fetch, handing the assembled line to the cache.
module line_fill_engine
    import cache_pkg::*;
#(
    parameter int ADDR_W      = CACHE_ADDR_W,
    parameter int LINE_BYTES  = CACHE_LINE_BYTES,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic                    req_wb,
    input  logic [ADDR_W-1:0]       req_wb_addr,
    input  logic [LINE_BYTES*8-1:0] req_wb_line,
    output logic                    fill_valid,
    input  logic                    fill_ready,
    output logic [ADDR_W-1:0]       fill_addr,
    output logic [LINE_BYTES*8-1:0] fill_line,
    output logic [31:0]             mem_addr,
    output logic [7:0]              mem_wdata,
    output logic                    mem_is_write,
    input  logic [7:0]              mem_rdata,
    output logic                    busy
);

    localparam int OFF_W  = off_width(LINE_BYTES);
    localparam int BASE_W = ADDR_W - OFF_W;

    state_t             state_reg;
    logic [BASE_W-1:0]  fill_base_reg;
    logic [BASE_W-1:0]  wb_base_reg;
    logic [7:0]         wb_bytes_reg   [LINE_BYTES];
    logic [7:0]         line_bytes_reg [LINE_BYTES];

    logic [OFF_W-1:0]   beat_idx;
    logic               beat_last_cycle;
    logic               line_done;

    line_beat_sequencer #(
        .LINE_BYTES  (LINE_BYTES),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_seq (
        .clk             (clk),
        .rst_n           (rst_n),
        .active          ((state_reg == WB) || (state_reg == FILL)),
        .beat_idx        (beat_idx),
        .beat_last_cycle (beat_last_cycle),
        .line_done       (line_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            fill_base_reg <= '0;
            wb_base_reg   <= '0;
            for (int i = 0; i < LINE_BYTES; i++) begin
                wb_bytes_reg[i]   <= '0;
                line_bytes_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        fill_base_reg <= req_addr[ADDR_W-1:OFF_W];
                        wb_base_reg   <= req_wb_addr[ADDR_W-1:OFF_W];
                        for (int i = 0; i < LINE_BYTES; i++) begin
                            wb_bytes_reg[i] <= req_wb_line[8*i +: 8];
                        end
                        state_reg <= req_wb ? WB : FILL;
                    end
                end
                WB: begin
                    if (line_done) state_reg <= FILL;
                end
                FILL: begin
                    // Sample on the final cycle so slow memories get the full hold time.
                    if (beat_last_cycle) line_bytes_reg[beat_idx] <= mem_rdata;
                    if (line_done) state_reg <= DONE;
                end
                DONE: begin
                    if (fill_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Base concatenated with the beat index never carries out of the line.
    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_is_write = 1'b0;
        case (state_reg)
            WB: begin
                mem_addr     = 32'({wb_base_reg, beat_idx});
                mem_wdata    = wb_bytes_reg[beat_idx];
                mem_is_write = 1'b1;
            end
            FILL: begin
                mem_addr = 32'({fill_base_reg, beat_idx});
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_pack
        assign fill_line[8*gi +: 8] = line_bytes_reg[gi];
    end

    assign fill_addr  = {fill_base_reg, {OFF_W{1'b0}}};
    assign req_ready  = (state_reg == IDLE);
    assign fill_valid = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench for line_fill_engine: one zero-wait instance and one
// instance with two wait cycles, each backed by a memory returning addr[7:0].
module tb_line_fill_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] req_addr = '0;
    logic        req_wb = 1'b0;
    logic [31:0] req_wb_addr = '0;
    logic [31:0] req_wb_line = '0;

    logic        req_valid0 = 1'b0, fill_ready0 = 1'b0;
    logic        req_ready0, fill_valid0, mem_is_write0, busy0;
    logic [31:0] fill_addr0, fill_line0, mem_addr0;
    logic [7:0]  mem_wdata0, mem_rdata0;

    logic        req_valid2 = 1'b0, fill_ready2 = 1'b0;
    logic        req_ready2, fill_valid2, mem_is_write2, busy2;
    logic [31:0] fill_addr2, fill_line2, mem_addr2;
    logic [7:0]  mem_wdata2, mem_rdata2;

    always #5 clk = ~clk;

    assign mem_rdata0 = mem_addr0[7:0];
    assign mem_rdata2 = mem_addr2[7:0];

    line_fill_engine #(.ADDR_W(32), .LINE_BYTES(4), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr),
        .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_line(req_wb_line),
        .fill_valid(fill_valid0), .fill_ready(fill_ready0),
        .fill_addr(fill_addr0), .fill_line(fill_line0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_is_write(mem_is_write0), .mem_rdata(mem_rdata0), .busy(busy0)
    );

    line_fill_engine #(.ADDR_W(32), .LINE_BYTES(4), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr),
        .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_line(req_wb_line),
        .fill_valid(fill_valid2), .fill_ready(fill_ready2),
        .fill_addr(fill_addr2), .fill_line(fill_line2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_is_write(mem_is_write2), .mem_rdata(mem_rdata2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request into dut0 and checks every beat up to fill_valid.
    task automatic do_req(input logic wb, input logic [31:0] wb_addr, input logic [31:0] wb_line,
                          input logic [31:0] addr, input logic [31:0] exp_base,
                          input logic [31:0] exp_wb_base, input logic [31:0] exp_line);
        req_wb = wb; req_wb_addr = wb_addr; req_wb_line = wb_line; req_addr = addr;
        req_valid0 = 1'b1;
        chk("req_ready_idle", req_ready0, 1);
        step();
        req_valid0 = 1'b0;
        req_addr = 32'hDEAD_BEEF; req_wb_addr = 32'h5555_5555; req_wb_line = 32'h0; req_wb = 1'b0;
        if (wb) begin
            for (int k = 0; k < 4; k++) begin
                chk("wb_addr", mem_addr0, exp_wb_base + 32'(k));
                chk("wb_wdata", mem_wdata0, wb_line[8*k +: 8]);
                chk("wb_is_write", mem_is_write0, 1);
                chk("wb_fill_valid", fill_valid0, 0);
                step();
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk("rd_addr", mem_addr0, exp_base + 32'(k));
            chk("rd_is_write", mem_is_write0, 0);
            chk("rd_wdata", mem_wdata0, 0);
            chk("rd_fill_valid", fill_valid0, 0);
            step();
        end
        chk("fill_valid", fill_valid0, 1);
        chk("fill_line", fill_line0, exp_line);
        chk("fill_addr", fill_addr0, exp_base);
        chk("busy_done", busy0, 1);
        $display("txn wb=%0d addr=0x%08h line=0x%08h", wb, addr, fill_line0);
    endtask

    task automatic accept_fill(input int stall, input logic [31:0] exp_line);
        for (int i = 0; i < stall; i++) begin
            chk("bp_fill_valid", fill_valid0, 1);
            chk("bp_fill_line", fill_line0, exp_line);
            chk("bp_is_write", mem_is_write0, 0);
            chk("bp_mem_addr", mem_addr0, 0);
            chk("bp_req_ready", req_ready0, 0);
            step();
        end
        fill_ready0 = 1'b1;
        step();
        fill_ready0 = 1'b0;
        chk("post_req_ready", req_ready0, 1);
        chk("post_fill_valid", fill_valid0, 0);
        chk("post_busy", busy0, 0);
        chk("post_line_hold", fill_line0, exp_line);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_req_ready", req_ready0, 1);
        chk("rst_fill_valid", fill_valid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_mem_addr", mem_addr0, 0);
        chk("rst_is_write", mem_is_write0, 0);
        chk("rst_fill_line", fill_line0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Plain fill
        do_req(1'b0, 32'h0, 32'h0, 32'h0000_1236, 32'h0000_1234, 32'h0, 32'h3736_3534);
        accept_fill(0, 32'h3736_3534);

        // Write-back then fill, with 5 cycles of backpressure
        do_req(1'b1, 32'h80, 32'hDDCC_BBAA, 32'h40, 32'h40, 32'h80, 32'h4342_4140);
        accept_fill(5, 32'h4342_4140);

        // Wait states on dut2
        req_wb = 1'b0; req_addr = 32'h10;
        req_valid2 = 1'b1;
        chk("ws_req_ready", req_ready2, 1);
        step();
        req_valid2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                chk("ws_addr", mem_addr2, 32'h10 + 32'(k));
                chk("ws_fill_valid", fill_valid2, 0);
                step();
            end
        end
        chk("ws_fill_valid_rise", fill_valid2, 1);
        chk("ws_fill_line", fill_line2, 32'h1312_1110);
        $display("txn ws addr=0x10 line=0x%08h", fill_line2);
        fill_ready2 = 1'b1;
        step();
        fill_ready2 = 1'b0;
        chk("ws_idle", req_ready2, 1);

        // Reset during write-back beat 1
        req_wb = 1'b1; req_wb_addr = 32'h80; req_wb_line = 32'h4433_2211; req_addr = 32'h20;
        req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        step();
        chk("mid_wb_addr", mem_addr0, 32'h81);
        chk("mid_wb_is_write", mem_is_write0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_is_write", mem_is_write0, 0);
        chk("async_req_ready", req_ready0, 1);
        #2 rst_n = 1'b1;
        step();
        chk("rel_req_ready", req_ready0, 1);
        chk("rel_fill_valid", fill_valid0, 0);
        $display("txn reset mid write-back");
        do_req(1'b0, 32'h0, 32'h0, 32'h0000_0024, 32'h0000_0024, 32'h0, 32'h2726_2524);
        accept_fill(0, 32'h2726_2524);

        // Top of memory
        do_req(1'b0, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0, 32'hFFFE_FDFC);
        accept_fill(1, 32'hFFFE_FDFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_fill_engine.md
Name: line_fill_engine

Overview:
- Sits between the cache controller and main memory, directly upstream of the main memory byte port.
- On a miss, it optionally writes back a dirty victim line byte-by-byte, then reads the missing line byte-by-byte.
- It assembles the fetched bytes into a line buffer and hands the full line to the cache over a valid/ready handshake.
- Main memory is combinational, 8-bit data and 32-bit address; this block supplies all sequencing.

Parameters:
- ADDR_W, 32, address width; must match the main memory address port.
- LINE_BYTES, 4, bytes per cache line; power of two, range 2..16.
- WAIT_CYCLES, 0, extra cycles each memory beat is held before it is sampled or retired.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  miss request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_W  miss address; low log2(LINE_BYTES) bits ignored.
- req_wb  in  1  victim line is dirty; write it back before the fill.
- req_wb_addr  in  ADDR_W  victim address; low bits ignored.
- req_wb_line  in  LINE_BYTES*8  victim data; byte i in bits [8i+7:8i].
- fill_valid  out  1  assembled line available.
- fill_ready  in  1  cache accepts the line.
- fill_addr  out  ADDR_W  aligned base address of the fetched line.
- fill_line  out  LINE_BYTES*8  fetched line; byte i in bits [8i+7:8i].
- mem_addr  out  32  to main memory Address.
- mem_wdata  out  8  to main memory Data.
- mem_is_write  out  1  to main memory isWrite.
- mem_rdata  in  8  from main memory outputdata.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, except req_ready=1.
  - The line buffer and beat/wait counters clear.
  - A reset mid-operation discards the in-flight line and drops mem_is_write immediately, without waiting for a clock edge.
- Request capture: on the edge where req_valid && req_ready, the block registers:
  - the aligned miss base,
  - the aligned write-back base,
  - req_wb_line,
  - req_wb.
  - Next state is WB if req_wb=1, else FILL.
- WB state:
  - Beat k drives mem_addr = wb_base+k, mem_wdata = byte k of the captured line, mem_is_write=1.
  - Each beat lasts WAIT_CYCLES+1 cycles.
  - After beat LINE_BYTES-1 the block moves to FILL. The beat counter resets to 0 and mem_is_write deasserts on that same edge.
- FILL state:
  - Beat k drives mem_addr = fill_base+k, mem_is_write=0, mem_wdata=0.
  - mem_rdata is captured into byte k of the line buffer on the last cycle of the beat.
  - After beat LINE_BYTES-1 the block moves to DONE.
- DONE state:
  - fill_valid=1; fill_line and fill_addr are stable.
  - mem_addr=0, mem_is_write=0.
  - Stays in DONE while fill_ready=0; no memory activity occurs.
  - On the edge where fill_valid && fill_ready, moves to IDLE. req_ready rises the following cycle; there is no same-cycle re-accept.
- IDLE state: mem_addr=0, mem_wdata=0, mem_is_write=0.
- Latency, measured from the accept edge to the fill_valid rise:
  - without write-back: LINE_BYTES*(WAIT_CYCLES+1) cycles;
  - with write-back: twice that.
- Address arithmetic:
  - Base = addr & ~(LINE_BYTES-1).
  - base+k never carries past the line, because k < LINE_BYTES.
  - Address 0xFFFF_FFFC with LINE_BYTES=4 produces beats FC..FF with no wrap to 0.
- Counters:
  - The beat counter is log2(LINE_BYTES) bits; the wait counter is sized for WAIT_CYCLES (minimum 1 bit).
  - Both reset to 0 on every state entry.
- Changes to req_* while busy are ignored; only captured values are used.
- fill_line holds its value after the handshake until the next capture overwrites it.

Decomposition:
- Shared package cache_pkg holds:
  - the LINE_BYTES default and the ADDR_W=32 constant;
  - the offset width function clog2(LINE_BYTES);
  - the state enum {IDLE, WB, FILL, DONE}.
- One natural sub-module, line_beat_sequencer. It owns the wait and beat counters and emits beat_idx, beat_last_cycle and line_done. The FSM and datapath stay in line_fill_engine.

Test Plan:
- Plain fill. Memory model returns Address[7:0]; LINE_BYTES=4, WAIT_CYCLES=0, req_addr=0x0000_1236, req_wb=0.
  Required: mem_addr sequence 0x1234, 0x1235, 0x1236, 0x1237; fill_addr=0x1234; fill_line=0x37363534; fill_valid rises 4 cycles after accept.
- Write-back then fill. req_wb=1, req_wb_addr=0x80, req_wb_line=0xDDCCBBAA, req_addr=0x40.
  Required: 4 write beats at 0x80..0x83 with mem_wdata AA, BB, CC, DD and mem_is_write=1; then 4 read beats at 0x40..0x43; fill_line=0x43424140; fill_valid after 8 cycles.
- Wait states. WAIT_CYCLES=2, req_addr=0x10.
  Required: each mem_addr is held exactly 3 cycles; fill_valid rises 12 cycles after accept; fill_line=0x13121110.
- Backpressure. fill_ready held 0 for 5 cycles after fill_valid.
  Required: fill_valid stays 1, fill_line is stable, mem_is_write=0 and mem_addr=0 throughout; req_ready stays 0; IDLE is reached one cycle after fill_ready=1.
- Reset mid write-back. rst_n pulsed low during WB beat 1.
  Required: mem_is_write drops to 0 asynchronously; req_ready=1 and fill_valid=0 after release; a new request completes normally.
- Top-of-memory boundary. req_addr=0xFFFF_FFFE.
  Required: beats at 0xFFFF_FFFC..0xFFFF_FFFF; fill_line=0xFFFEFDFC; no address wrap.
